// File: rtl/branch_resolve_unit_if.sv
// ============================================================================
// branch_resolve_unit_if : op/result bundle between decode, resolver and fetch
// Rev 1.0
// ============================================================================
`default_nettype none

interface branch_resolve_unit_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic             is_branch;
   logic             is_jal;
   logic             is_jalr;
   logic [2:0]       funct3;
   logic             br_eq;
   logic             br_lt;
   logic             br_ltu;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  imm;
   logic [XLEN-1:0]  rs1;
   logic             pred_taken;
   logic             out_valid;
   logic             out_ready;
   logic             taken;
   logic [XLEN-1:0]  target;
   logic             illegal;
   logic             redirect;
   logic [XLEN-1:0]  redirect_pc;
   logic             flush;
   logic [CNT_W-1:0] br_count;
   logic [CNT_W-1:0] mispred_count;

   modport master (
      output in_valid, is_branch, is_jal, is_jalr, funct3, br_eq, br_lt, br_ltu,
             pc, imm, rs1, pred_taken, out_ready,
      input  in_ready, out_valid, taken, target, illegal, redirect, redirect_pc,
             flush, br_count, mispred_count
   );

   modport slave (
      input  in_valid, is_branch, is_jal, is_jalr, funct3, br_eq, br_lt, br_ltu,
             pc, imm, rs1, pred_taken, out_ready,
      output in_ready, out_valid, taken, target, illegal, redirect, redirect_pc,
             flush, br_count, mispred_count
   );
endinterface

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// branch_resolve_unit : resolves branch/jump direction+target, redirects and
// flushes fetch on mispredict. Rev 1.0
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  wire logic            clk,
   input  wire logic            rst,
   branch_resolve_unit_if.slave bus
);
   localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
   localparam logic [FCW-1:0]   C_FLUSH_LOAD = FCW'(FLUSH_CYCLES);
   localparam logic [FCW-1:0]   C_FCNT_ONE   = FCW'(1);
   localparam logic [XLEN-1:0]  C_FOUR       = XLEN'(4);
   localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t           r_state;
   logic [FCW-1:0]   r_flush_cnt;
   logic             r_out_valid;
   logic             r_taken;
   logic [XLEN-1:0]  r_target;
   logic             r_illegal;
   logic             r_redirect;
   logic [XLEN-1:0]  r_redirect_pc;
   logic             r_flush;
   logic [CNT_W-1:0] r_br_count;
   logic [CNT_W-1:0] r_mispred_count;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_is_cti;
   logic             w_taken;
   logic             w_illegal;
   logic             w_mispred;
   logic [XLEN-1:0]  w_pc4;
   logic [XLEN-1:0]  w_pc_imm;
   logic [XLEN-1:0]  w_rs1_imm;
   logic [XLEN-1:0]  w_target;

   assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_is_cti   = bus.is_jalr || bus.is_jal || bus.is_branch;
   assign w_pc4      = bus.pc + C_FOUR;
   assign w_pc_imm   = bus.pc + bus.imm;
   assign w_rs1_imm  = bus.rs1 + bus.imm;

   always_comb begin
      w_taken   = 1'b0;
      w_illegal = 1'b0;
      w_mispred = 1'b0;
      w_target  = w_pc4;
      if (bus.is_jalr) begin
         w_taken   = 1'b1;
         w_target  = {w_rs1_imm[XLEN-1:1], 1'b0};
         // no target predictor, so every JALR refetches
         w_mispred = 1'b1;
      end else if (bus.is_jal) begin
         w_taken   = 1'b1;
         w_target  = w_pc_imm;
         w_mispred = !bus.pred_taken;
      end else if (bus.is_branch) begin
         w_target = w_pc_imm;
         case (bus.funct3)
            3'b000:  w_taken = bus.br_eq;
            3'b001:  w_taken = !bus.br_eq;
            3'b100:  w_taken = bus.br_lt;
            3'b101:  w_taken = !bus.br_lt;
            3'b110:  w_taken = bus.br_ltu;
            3'b111:  w_taken = !bus.br_ltu;
            default: w_illegal = 1'b1;
         endcase
         w_mispred = (w_taken != bus.pred_taken);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= ST_RUN;
         r_flush_cnt     <= '0;
         r_out_valid     <= 1'b0;
         r_taken         <= 1'b0;
         r_target        <= '0;
         r_illegal       <= 1'b0;
         r_redirect      <= 1'b0;
         r_redirect_pc   <= '0;
         r_flush         <= 1'b0;
         r_br_count      <= '0;
         r_mispred_count <= '0;
      end else begin
         r_redirect <= 1'b0;
         if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_taken       <= w_taken;
            r_target      <= w_target;
            r_illegal     <= w_illegal;
            r_redirect_pc <= w_taken ? w_target : w_pc4;
            if (w_is_cti && (r_br_count != C_CNT_MAX))
               r_br_count <= r_br_count + C_CNT_ONE;
            if (w_mispred) begin
               r_redirect <= 1'b1;
               if (r_mispred_count != C_CNT_MAX)
                  r_mispred_count <= r_mispred_count + C_CNT_ONE;
               if (FLUSH_CYCLES != 0) begin
                  r_state     <= ST_FLUSH;
                  r_flush     <= 1'b1;
                  r_flush_cnt <= C_FLUSH_LOAD;
               end
            end
         end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end

         // accept is impossible in FLUSH, so this never races the load above
         if (r_state == ST_FLUSH) begin
            if (r_flush_cnt <= C_FCNT_ONE) begin
               r_state     <= ST_RUN;
               r_flush     <= 1'b0;
               r_flush_cnt <= '0;
            end else begin
               r_flush_cnt <= r_flush_cnt - C_FCNT_ONE;
            end
         end
      end
   end

   assign bus.in_ready      = w_in_ready;
   assign bus.out_valid     = r_out_valid;
   assign bus.taken         = r_taken;
   assign bus.target        = r_target;
   assign bus.illegal       = r_illegal;
   assign bus.redirect      = r_redirect;
   assign bus.redirect_pc   = r_redirect_pc;
   assign bus.flush         = r_flush;
   assign bus.br_count      = r_br_count;
   assign bus.mispred_count = r_mispred_count;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// tb_branch_resolve_unit : directed scoreboard bench for branch_resolve_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;
   localparam int FLUSH = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_resolve_unit_if #(.XLEN(32), .CNT_W(32)) bus ();
   branch_resolve_unit_if #(.XLEN(32), .CNT_W(2))  sbus ();

   branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(FLUSH), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   // narrow counters and no flush state: exercises saturation and FLUSH_CYCLES=0
   branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(0), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .bus(sbus)
   );

   typedef struct {
      logic        taken;
      logic [31:0] target;
      logic        illegal;
      logic [31:0] rpc;
      logic        mispred;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          flush_left = 0;
   logic        fresh = 1'b0;
   logic [31:0] exp_br = '0;
   logic [31:0] exp_mis = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model();
      exp_t        e;
      logic [31:0] s;
      e.taken   = 1'b0;
      e.illegal = 1'b0;
      e.mispred = 1'b0;
      e.target  = bus.pc + bus.imm;
      if (bus.is_jalr) begin
         s         = bus.rs1 + bus.imm;
         e.target  = s & 32'hFFFF_FFFE;
         e.taken   = 1'b1;
         e.mispred = 1'b1;
      end else if (bus.is_jal) begin
         e.taken   = 1'b1;
         e.mispred = (bus.pred_taken == 1'b0);
      end else if (bus.is_branch) begin
         unique case (bus.funct3)
            3'b000: e.taken = (bus.br_eq == 1'b1);
            3'b001: e.taken = (bus.br_eq == 1'b0);
            3'b100: e.taken = (bus.br_lt == 1'b1);
            3'b101: e.taken = (bus.br_lt == 1'b0);
            3'b110: e.taken = (bus.br_ltu == 1'b1);
            3'b111: e.taken = (bus.br_ltu == 1'b0);
            default: e.illegal = 1'b1;
         endcase
         e.mispred = (e.taken !== bus.pred_taken);
      end else begin
         e.target = bus.pc + 32'd4;
      end
      e.rpc = e.taken ? e.target : (bus.pc + 32'd4);
      return e;
   endfunction

   task automatic op(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                     input logic eq, input logic lt, input logic ltu, input logic [31:0] pc,
                     input logic [31:0] imm, input logic [31:0] rs1, input logic pred);
      bus.in_valid   = 1'b1;
      bus.is_branch  = br;
      bus.is_jal     = jal;
      bus.is_jalr    = jalr;
      bus.funct3     = f3;
      bus.br_eq      = eq;
      bus.br_lt      = lt;
      bus.br_ltu     = ltu;
      bus.pc         = pc;
      bus.imm        = imm;
      bus.rs1        = rs1;
      bus.pred_taken = pred;
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.is_branch = 1'b0;
      bus.is_jal    = 1'b0;
      bus.is_jalr   = 1'b0;
   endtask

   // One cycle: check outputs at negedge, pop/push scoreboard, advance past posedge.
   task automatic tick();
      logic exp_ir;
      logic acc;
      logic mis;
      exp_t e;
      @(negedge clk);
      exp_ir = (flush_left == 0) && ((q.size() == 0) || bus.out_ready);
      chk("in_ready", bus.in_ready, exp_ir);
      chk("out_valid", bus.out_valid, q.size() != 0);
      chk("flush", bus.flush, flush_left != 0);
      chk("br_count", bus.br_count, exp_br);
      chk("mispred_count", bus.mispred_count, exp_mis);
      if (q.size() != 0) begin
         chk("taken", bus.taken, q[0].taken);
         chk("target", bus.target, q[0].target);
         chk("illegal", bus.illegal, q[0].illegal);
         chk("redirect_pc", bus.redirect_pc, q[0].rpc);
         chk("redirect", bus.redirect, fresh ? q[0].mispred : 1'b0);
         if (bus.out_ready) void'(q.pop_front());
      end else begin
         chk("redirect_idle", bus.redirect, 1'b0);
      end
      acc = bus.in_valid && exp_ir;
      mis = 1'b0;
      if (acc) begin
         e = model();
         q.push_back(e);
         mis = e.mispred;
         if ((bus.is_branch || bus.is_jal || bus.is_jalr) && exp_br != '1) exp_br++;
         if (mis && exp_mis != '1) exp_mis++;
      end
      @(posedge clk);
      #1;
      if (acc && mis && FLUSH > 0) flush_left = FLUSH;
      else if (flush_left > 0) flush_left--;
      fresh = acc;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      bus.funct3 = 3'b000; bus.br_eq = 1'b0; bus.br_lt = 1'b0; bus.br_ltu = 1'b0;
      bus.pc = '0; bus.imm = '0; bus.rs1 = '0; bus.pred_taken = 1'b0;
      bus.out_ready = 1'b1;
      sbus.in_valid = 1'b0; sbus.is_branch = 1'b0; sbus.is_jal = 1'b0; sbus.is_jalr = 1'b0;
      sbus.funct3 = 3'b000; sbus.br_eq = 1'b0; sbus.br_lt = 1'b0; sbus.br_ltu = 1'b0;
      sbus.pc = '0; sbus.imm = '0; sbus.rs1 = '0; sbus.pred_taken = 1'b0;
      sbus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_target", bus.target, 32'h0);
      chk("rst_flush", bus.flush, 1'b0);
      chk("rst_br_count", bus.br_count, 32'h0);
      tick();

      // BEQ taken, correctly predicted
      op(1, 0, 0, 3'b000, 1, 0, 0, 32'h100, 32'h20, 32'h0, 1);
      tick(); idle();
      chk("t1_taken", bus.taken, 1'b1);
      chk("t1_target", bus.target, 32'h120);
      chk("t1_redirect", bus.redirect, 1'b0);
      chk("t1_br_count", bus.br_count, 32'd1);
      tick();

      // BLTU not taken but predicted taken: redirect + 2-cycle flush
      op(1, 0, 0, 3'b110, 0, 0, 0, 32'h200, 32'h40, 32'h0, 1);
      tick();
      chk("t2_taken", bus.taken, 1'b0);
      chk("t2_redirect", bus.redirect, 1'b1);
      chk("t2_rpc", bus.redirect_pc, 32'h204);
      chk("t2_flush", bus.flush, 1'b1);
      chk("t2_in_ready", bus.in_ready, 1'b0);
      chk("t2_mis", bus.mispred_count, 32'd1);
      op(1, 0, 0, 3'b000, 0, 0, 0, 32'h300, 32'h10, 32'h0, 0);
      tick();
      chk("t2_flush2", bus.flush, 1'b1);
      chk("t2_redirect_once", bus.redirect, 1'b0);
      tick();
      chk("t2_flush_end", bus.flush, 1'b0);
      chk("t2_ready_back", bus.in_ready, 1'b1);
      tick(); idle();
      tick();

      // JALR target LSB cleared; then branch target wraps
      op(0, 0, 1, 3'b000, 0, 0, 0, 32'h400, 32'h4, 32'h1003, 1);
      tick(); idle();
      chk("t3_jalr_target", bus.target, 32'h1006);
      chk("t3_jalr_redirect", bus.redirect, 1'b1);
      tick(); tick();
      op(1, 0, 0, 3'b000, 1, 0, 0, 32'hFFFF_FFFC, 32'h8, 32'h0, 1);
      tick(); idle();
      chk("t3_wrap_target", bus.target, 32'h4);
      tick();

      // backpressure: result held, no accept while stalled
      op(1, 0, 0, 3'b001, 0, 0, 0, 32'h500, 32'h10, 32'h0, 1);
      tick();
      bus.out_ready = 1'b0;
      op(1, 0, 0, 3'b100, 0, 1, 0, 32'h600, 32'hFFFF_FFF8, 32'h0, 1);
      repeat (3) tick();
      chk("t4_hold_target", bus.target, 32'h510);
      chk("t4_hold_ready", bus.in_ready, 1'b0);
      bus.out_ready = 1'b1;
      tick();
      chk("t4_reload_target", bus.target, 32'h5F8);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) op(0, 0, 0, 3'b000, 0, 0, 0, 32'h800, 32'h40, 32'h0, 0);
         else op(1, 0, 0, 3'b101, i[0], i[0], 0, 32'h700 + 32'(i * 16), 32'h100, 32'h0, !i[0]);
         tick();
         chk("t4_b2b_valid", bus.out_valid, 1'b1);
      end
      idle();
      tick(); tick();

      // illegal funct3
      op(1, 0, 0, 3'b010, 1, 1, 1, 32'h900, 32'h20, 32'h0, 0);
      tick(); idle();
      chk("t5_illegal", bus.illegal, 1'b1);
      chk("t5_ill_taken", bus.taken, 1'b0);
      tick();

      // JAL predicted not-taken, then reset in the middle of the flush
      op(0, 1, 0, 3'b000, 0, 0, 0, 32'hA00, 32'h100, 32'h0, 0);
      tick(); idle();
      chk("t5_jal_rpc", bus.redirect_pc, 32'hB00);
      chk("t5_jal_flush", bus.flush, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_valid", bus.out_valid, 1'b0);
      chk("t5_rst_taken", bus.taken, 1'b0);
      chk("t5_rst_target", bus.target, 32'h0);
      chk("t5_rst_redirect", bus.redirect, 1'b0);
      chk("t5_rst_rpc", bus.redirect_pc, 32'h0);
      chk("t5_rst_flush", bus.flush, 1'b0);
      chk("t5_rst_br", bus.br_count, 32'h0);
      chk("t5_rst_mis", bus.mispred_count, 32'h0);
      q.delete();
      flush_left = 0; exp_br = '0; exp_mis = '0; fresh = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("t5_ready_after_rst", bus.in_ready, 1'b1);
      op(1, 0, 0, 3'b000, 1, 0, 0, 32'hC00, 32'h8, 32'h0, 1);
      tick(); idle();
      tick();

      // counter saturation on the narrow instance
      sbus.in_valid = 1'b1;
      sbus.is_jalr  = 1'b1;
      sbus.rs1      = 32'h2000;
      repeat (2) @(posedge clk);
      #1;
      chk("t6_br_two", 32'(sbus.br_count), 32'd2);
      repeat (4) begin
         @(negedge clk);
         chk("t6_no_flush", sbus.flush, 1'b0);
      end
      sbus.in_valid = 1'b0;
      @(negedge clk);
      chk("t6_br_sat", 32'(sbus.br_count), 32'd3);
      chk("t6_mis_sat", 32'(sbus.mispred_count), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
